discharge_pulse_gen: RTL and testbench

DISCHARGE_PULSE_GEN -- requirements
Module: discharge_pulse_gen

---
 rtl/discharge_pulse_gen.sv | 107 ++++++++++
 tb/tb_discharge_pulse_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/discharge_pulse_gen.sv
// Discharge pulse generator: repeating Ton/Toff gate pattern timed in units of CLK_PER_UNIT
// cycles, with stop priority, per-period parameter latching and a completed-period counter.
module discharge_pulse_gen #(
  parameter int unsigned CLK_PER_UNIT = 100,
  parameter int unsigned TOFF_MIN     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        machine_start,
  input  logic        machine_stop,
  input  logic [15:0] Ton_data,
  input  logic [15:0] Toff_data,
  output logic        pulse_gate,
  output logic        running,
  output logic        period_done,
  output logic [15:0] pulse_cnt
);

  localparam int unsigned PW = (CLK_PER_UNIT > 1) ? $clog2(CLK_PER_UNIT) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_PER_UNIT - 1);
  localparam logic [15:0] ToffMin = 16'(TOFF_MIN);

  typedef enum logic [1:0] {StIdle, StTon, StToff} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   unit_q, unit_d;
  logic [15:0]   ton_q, ton_d;
  logic [15:0]   toff_q, toff_d;

  logic          gate_d, running_d, period_done_d;
  logic [15:0]   cnt_d;
  logic          unit_end, ton_end, toff_end, start_ok, new_period;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      presc_q     <= '0;
      unit_q      <= '0;
      ton_q       <= '0;
      toff_q      <= '0;
      pulse_gate  <= 1'b0;
      running     <= 1'b0;
      period_done <= 1'b0;
      pulse_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      unit_q      <= unit_d;
      ton_q       <= ton_d;
      toff_q      <= toff_d;
      pulse_gate  <= gate_d;
      running     <= running_d;
      period_done <= period_done_d;
      pulse_cnt   <= cnt_d;
    end
  end

  always_comb begin
    unit_end   = (presc_q == PrescMax);
    ton_end    = (state_q == StTon) && unit_end && (unit_q == ton_q - 16'd1);
    toff_end   = (state_q == StToff) && unit_end && (unit_q == toff_q - 16'd1);
    start_ok   = (state_q == StIdle) && machine_start && !machine_stop;
    new_period = start_ok || (toff_end && !machine_stop);

    state_d = state_q;
    ton_d   = ton_q;
    toff_d  = toff_q;
    if (unit_end) begin
      presc_d = '0;
      unit_d  = unit_q + 16'd1;
    end else begin
      presc_d = presc_q + PW'(1);
      unit_d  = unit_q;
    end

    if (machine_stop) begin
      state_d = StIdle;
      presc_d = '0;
      unit_d  = '0;
    end else if (new_period) begin
      ton_d   = Ton_data;
      toff_d  = (Toff_data < ToffMin) ? ToffMin : Toff_data;
      // A zero Ton skips TON entirely so the gate never pulses for a cycle.
      state_d = (Ton_data == 16'd0) ? StToff : StTon;
      presc_d = '0;
      unit_d  = '0;
    end else if (ton_end) begin
      state_d = StToff;
      presc_d = '0;
      unit_d  = '0;
    end else if (state_q == StIdle) begin
      presc_d = '0;
      unit_d  = '0;
    end
  end

  // Outputs are registered, so they are derived from the next state and counters.
  always_comb begin
    gate_d        = (state_d == StTon);
    running_d     = (state_d != StIdle);
    period_done_d = (state_d == StToff) && (presc_d == PrescMax) &&
                    (unit_d == toff_d - 16'd1);
    cnt_d         = (start_ok ? 16'd0 : pulse_cnt) + {15'd0, period_done_d};
  end

endmodule

// File: tb/tb_discharge_pulse_gen.sv
// Directed bench for discharge_pulse_gen: a CLK_PER_UNIT=100 instance for timing/strobe cases
// and a CLK_PER_UNIT=1 instance for the short-period and pulse_cnt wrap cases.
module tb_discharge_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] ton = 16'd0, toff = 16'd0;
  logic        gate, run, pd;
  logic [15:0] cnt;

  logic        start1 = 1'b0, stop1 = 1'b0;
  logic [15:0] ton1 = 16'd0, toff1 = 16'd0;
  logic        gate1, run1, pd1;
  logic [15:0] cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  discharge_pulse_gen #(.CLK_PER_UNIT(100), .TOFF_MIN(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .machine_start(start),
    .machine_stop (stop),
    .Ton_data     (ton),
    .Toff_data    (toff),
    .pulse_gate   (gate),
    .running      (run),
    .period_done  (pd),
    .pulse_cnt    (cnt)
  );

  discharge_pulse_gen #(.CLK_PER_UNIT(1), .TOFF_MIN(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .machine_start(start1),
    .machine_stop (stop1),
    .Ton_data     (ton1),
    .Toff_data    (toff1),
    .pulse_gate   (gate1),
    .running      (run1),
    .period_done  (pd1),
    .pulse_cnt    (cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // After tick, outputs reflect the cycle following the posedge numbered cyc.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) tick(1);
  endtask

  initial begin
    int b;
    int highs;
    int dones;

    // Reset
    tick(3);
    check("rst_gate", 32'(gate), 0);
    check("rst_running", 32'(run), 0);
    check("rst_done", 32'(pd), 0);
    check("rst_cnt", 32'(cnt), 0);
    rst_n = 1'b1;
    tick(5);
    check("idle_after_rst", 32'(run), 0);

    // Simultaneous start and stop in IDLE: stop wins
    start = 1'b1; stop = 1'b1; ton = 16'd5; toff = 16'd10;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(2);
    check("startstop_running", 32'(run), 0);
    check("startstop_gate", 32'(gate), 0);

    // Nominal period: start driven at cycle 0, gate high cycles 1..500, TOFF 501..1500
    cyc = 0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("nom_gate_c1", 32'(gate), 1);
    check("nom_run_c1", 32'(run), 1);
    check("nom_cnt_c1", 32'(cnt), 0);
    goto(500);
    check("nom_gate_c500", 32'(gate), 1);
    goto(501);
    check("nom_gate_c501", 32'(gate), 0);
    check("nom_run_c501", 32'(run), 1);
    goto(1499);
    check("nom_done_c1499", 32'(pd), 0);
    goto(1500);
    check("nom_done_c1500", 32'(pd), 1);
    check("nom_cnt_c1500", 32'(cnt), 1);
    goto(1501);
    check("nom_gate_c1501", 32'(gate), 1);
    check("nom_done_c1501", 32'(pd), 0);

    // Ton changed mid-pulse: this pulse stays 500, next pulse is 200
    ton = 16'd2;
    goto(2000);
    check("upd_gate_c2000", 32'(gate), 1);
    goto(2001);
    check("upd_gate_c2001", 32'(gate), 0);
    goto(3000);
    check("upd_cnt_c3000", 32'(cnt), 2);
    goto(3200);
    check("upd_gate_c3200", 32'(gate), 1);
    goto(3201);
    check("upd_gate_c3201", 32'(gate), 0);

    // Start during TOFF is ignored; Ton=5 is picked up at the next period
    goto(3300);
    start = 1'b1; ton = 16'd5;
    tick(1);
    start = 1'b0;
    goto(4199);
    check("toffstart_done_c4199", 32'(pd), 0);
    goto(4200);
    check("toffstart_done_c4200", 32'(pd), 1);
    check("toffstart_cnt_c4200", 32'(cnt), 3);

    // Stop at cycle 250 of Ton (TON began at 4201)
    goto(4450);
    check("stop_gate_before", 32'(gate), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("stop_gate", 32'(gate), 0);
    check("stop_running", 32'(run), 0);
    check("stop_done", 32'(pd), 0);
    check("stop_cnt_hold", 32'(cnt), 3);

    // Zero Ton / zero Toff clamped to one unit
    goto(4460);
    b = cyc;
    start = 1'b1; ton = 16'd0; toff = 16'd0;
    tick(1);
    start = 1'b0;
    check("zero_cnt_cleared", 32'(cnt), 0);
    check("zero_running", 32'(run), 1);
    highs = 0; dones = 0;
    if (gate) highs++;
    if (pd) dones++;
    while (cyc < b + 300) begin
      tick(1);
      if (gate) highs++;
      if (pd) dones++;
      if (cyc == b + 99) check("zero_done_c99", 32'(pd), 0);
      if (cyc == b + 100) check("zero_done_c100", 32'(pd), 1);
    end
    check("zero_gate_highs", 32'(highs), 0);
    check("zero_done_count", 32'(dones), 3);
    check("zero_cnt_end", 32'(cnt), 3);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;

    // CLK_PER_UNIT=1, Ton=1, Toff=1: two-cycle periods
    b = cyc;
    start1 = 1'b1; ton1 = 16'd1; toff1 = 16'd1;
    tick(1);
    start1 = 1'b0;
    check("u1_gate_c1", 32'(gate1), 1);
    check("u1_done_c1", 32'(pd1), 0);
    tick(1);
    check("u1_gate_c2", 32'(gate1), 0);
    check("u1_done_c2", 32'(pd1), 1);
    check("u1_cnt_c2", 32'(cnt1), 1);
    tick(1);
    check("u1_gate_c3", 32'(gate1), 1);
    tick(1);
    check("u1_cnt_c4", 32'(cnt1), 2);
    stop1 = 1'b1;
    tick(1);
    stop1 = 1'b0;
    check("u1_stop_running", 32'(run1), 0);

    // One-cycle periods: pulse_cnt wraps after 65536 periods
    b = cyc;
    start1 = 1'b1; ton1 = 16'd0; toff1 = 16'd0;
    tick(1);
    start1 = 1'b0;
    check("wrap_cnt_c1", 32'(cnt1), 1);
    highs = 0;
    while (cyc < b + 65535) begin
      tick(1);
      if (gate1) highs++;
    end
    check("wrap_cnt_ffff", 32'(cnt1), 32'h0000_ffff);
    tick(1);
    check("wrap_cnt_zero", 32'(cnt1), 0);
    check("wrap_gate_highs", 32'(highs), 0);
    stop1 = 1'b1;
    tick(1);
    stop1 = 1'b0;

    // Reset asserted mid-Ton drops everything on that edge
    start = 1'b1; ton = 16'd5; toff = 16'd10;
    tick(1);
    start = 1'b0;
    tick(99);
    check("rstmid_gate_before", 32'(gate), 1);
    rst_n = 1'b0;
    tick(1);
    check("rstmid_gate", 32'(gate), 0);
    check("rstmid_running", 32'(run), 0);
    check("rstmid_done", 32'(pd), 0);
    check("rstmid_cnt", 32'(cnt), 0);
    rst_n = 1'b1;
    tick(10);
    check("rstmid_stays_idle", 32'(run), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
